mem_burst_initiator: RTL and testbench
======================================

Name:
mem_burst_initiator

Overview:
Initiator-side controller that drives the byte-addressable memory's port set (address, data_in, access_size, rw, enable; observes busy, data_out) on behalf of a core-side requester. It takes one request of 1/4/8/16 words, sequences one word beat at a time with an auto-incremented address, and returns read words or consumes write words. It sits between the fetch/load-store logic and the memory.

Parameters:
START_ADDR, 32'h80020000, lowest valid byte address of the memory window
DEPTH, 1048576, window size in bytes; valid range is START_ADDR..START_ADDR+DEPTH-1
TIMEOUT_CYCLES, 255, consecutive mem_busy cycles tolerated per beat (used only with BUSY_TIMEOUT_EN)

Ports:
clock  input  1  single clock; all state updates on posedge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present; sampled only when req_ready=1
req_ready  output  1  high only in IDLE
req_addr  input  32  burst start byte address
req_rw  input  1  1=read, 0=write; same encoding as memory rw
req_size  input  2  00=1, 01=4, 10=8, 11=16 words
wdata  input  32  write word for the current beat
wdata_valid  input  1  wdata present
wdata_ready  output  1  1-cycle pulse; current write beat accepted by memory
resp_valid  output  1  1-cycle pulse; resp_data holds one read word
resp_data  output  32  read word, byte0 in [7:0]
resp_last  output  1  with resp_valid on final read beat
done  output  1  1-cycle pulse when burst completes (read or write)
err  output  1  1-cycle pulse on rejected request or abort
mem_address  output  32  to memory address
mem_data_in  output  32  to memory data_in
mem_access_size  output  2  to memory access_size; held = req_size for whole burst
mem_rw  output  1  to memory rw
mem_enable  output  1  to memory enable
mem_busy  input  1  from memory busy
mem_data_out  input  32  from memory data_out

Behaviour:
- Reset (async, any state): all outputs 0 except req_ready=1; state IDLE; beat counter 0; any burst in progress is dropped without done/err.
- States: IDLE, ACCESS, CAPTURE, FINISH. IDLE: on req_valid, latch addr/rw/size, beats=1/4/8/16, go to ACCESS; with a rejected request, pulse err next cycle and stay in IDLE.
- Reject when req_addr[1:0]!=0, req_addr<START_ADDR, or req_addr+4*beats-1 > START_ADDR+DEPTH-1; compute in 33 bits so wrap past 2^32 is rejected. Rejected requests never assert mem_enable.
- ACCESS: mem_address=current addr, mem_rw=latched rw, mem_access_size=latched size. Read: mem_enable=1. Write: mem_enable=wdata_valid, mem_data_in=wdata.
- A beat is accepted on a posedge with mem_enable=1 and mem_busy=0. mem_address, mem_rw and mem_data_in stay stable while mem_busy=1.
- Write beat accepted: wdata_ready pulses in that cycle. Then addr+=4 and count-- (stay in ACCESS), or go to FINISH on the last beat.
- Read beat accepted: go to CAPTURE with mem_enable=0. In CAPTURE, register mem_data_out into resp_data and pulse resp_valid the cycle after capture (resp_last on final beat). Then back to ACCESS, or FINISH on the last beat.
- Read latency: first resp_valid 2 cycles after acceptance; an unstalled N-word read takes 2N+1 cycles from request to done.
- FINISH: done pulses for 1 cycle, mem_enable=0, go to IDLE (req_ready=1 the following cycle).
- resp_valid has no backpressure; the consumer must take it.
- wdata_valid low in ACCESS is a legal stall: mem_enable=0 and no timeout count.

Optional Feature:
BUSY_TIMEOUT_EN defined: a counter increments each ACCESS cycle with mem_enable=1 and mem_busy=1, and clears on beat acceptance. On reaching TIMEOUT_CYCLES, drop mem_enable, pulse err (no done, no further resp_valid), and return to IDLE.
Not defined: no counter; the controller waits on mem_busy indefinitely.

Test Plan:
Single read addr 0x80020000, memory bytes 11,22,33,44, busy=0 -> one resp_valid+resp_last, resp_data=0x44332211, done 3 cycles after request.
4-word read at 0x80020010, busy held high 3 cycles on beat 2 -> mem_address 0x80020010/14/18/1C, 4 resp_valid, resp_last on the 4th, address stable during stall.
16-word write from 0x80020100, wdata_valid low 2 cycles mid-burst -> 16 wdata_ready pulses, mem_enable low during the gap, read-back matches, one done.
Request 0x80020002 size 00; request 0x8011FFF0 size 11 (end beyond window) -> err pulse each, mem_enable never asserted, req_ready back high.
reset_n low mid 8-word read, after beat 3 -> outputs zero immediately, no done/err; a fresh 1-word read afterwards completes normally. With BUSY_TIMEOUT_EN and TIMEOUT_CYCLES=4, busy stuck high -> err after 4 cycles, return to IDLE.

Source files
------------

// File: rtl/mem_burst_initiator.sv
// Burst initiator: turns one 1/4/8/16-word core request into word beats on the memory port.
// Optional busy watchdog is compiled in with `define BUSY_TIMEOUT_EN.
module mem_burst_initiator #(
    parameter logic [31:0] START_ADDR = 32'h8002_0000,
    parameter int unsigned DEPTH      = 1048576
`ifdef BUSY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [31:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic        mem_busy,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, FINISH} state_t;

    localparam logic [32:0] WIN_LAST = {1'b0, START_ADDR} + 33'(DEPTH) - 33'd1;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic        rw_q;
    logic [1:0]  size_q;
    logic [4:0]  count_q;
    logic [4:0]  req_beats;
    logic [32:0] req_end;
    logic        req_reject;
    logic        beat_accept;
    logic        last_beat;
    logic        timeout_hit;

    always_comb begin
        case (req_size)
            2'b00:   req_beats = 5'd1;
            2'b01:   req_beats = 5'd4;
            2'b10:   req_beats = 5'd8;
            default: req_beats = 5'd16;
        endcase
    end

    // 33-bit end address so a burst wrapping past 2^32 compares as out of window.
    assign req_end    = {1'b0, req_addr} + {26'd0, req_beats, 2'b00} - 33'd1;
    assign req_reject = (req_addr[1:0] != 2'b00) || (req_addr < START_ADDR) || (req_end > WIN_LAST);

    assign beat_accept = (state == ACCESS) && mem_enable && !mem_busy;
    assign last_beat   = (count_q == 5'd1);

`ifdef BUSY_TIMEOUT_EN
    logic [31:0] busy_cnt;

    assign timeout_hit = (state == ACCESS) && mem_enable && mem_busy &&
                         (busy_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            busy_cnt <= '0;
        else if (state != ACCESS || beat_accept || timeout_hit)
            busy_cnt <= '0;
        else if (mem_enable && mem_busy)
            busy_cnt <= busy_cnt + 32'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid && !req_reject) state_nxt = ACCESS;
            ACCESS: begin
                if (timeout_hit)
                    state_nxt = IDLE;
                else if (beat_accept)
                    state_nxt = rw_q ? CAPTURE : (last_beat ? FINISH : ACCESS);
            end
            CAPTURE: state_nxt = last_beat ? FINISH : ACCESS;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        req_ready       = 1'b0;
        wdata_ready     = 1'b0;
        done            = 1'b0;
        mem_enable      = 1'b0;
        mem_data_in     = '0;
        mem_address     = '0;
        mem_rw          = 1'b0;
        mem_access_size = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            ACCESS: begin
                mem_address     = addr_q;
                mem_rw          = rw_q;
                mem_access_size = size_q;
                if (rw_q) begin
                    mem_enable = 1'b1;
                end else begin
                    mem_enable  = wdata_valid;
                    mem_data_in = wdata;
                    wdata_ready = wdata_valid && !mem_busy;
                end
            end
            CAPTURE: begin
                mem_address     = addr_q;
                mem_rw          = rw_q;
                mem_access_size = size_q;
            end
            default: begin
                mem_address     = addr_q;
                mem_rw          = rw_q;
                mem_access_size = size_q;
                done            = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            rw_q       <= 1'b0;
            size_q     <= '0;
            count_q    <= '0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            err        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_reject) begin
                            err <= 1'b1;
                        end else begin
                            addr_q  <= req_addr;
                            rw_q    <= req_rw;
                            size_q  <= req_size;
                            count_q <= req_beats;
                        end
                    end
                end
                ACCESS: begin
                    if (timeout_hit) begin
                        err <= 1'b1;
                    end else if (beat_accept && !rw_q) begin
                        addr_q  <= addr_q + 32'd4;
                        count_q <= count_q - 5'd1;
                    end
                end
                CAPTURE: begin
                    resp_data  <= mem_data_out;
                    resp_valid <= 1'b1;
                    resp_last  <= last_beat;
                    addr_q     <= addr_q + 32'd4;
                    count_q    <= count_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Self-checking bench for mem_burst_initiator: byte-array memory model plus a
// request-level reference (window rule, beat addresses, expected words, latency).
module tb_mem_burst_initiator;

    localparam logic [31:0] START = 32'h8002_0000;
    localparam int unsigned DEPTH = 1048576;
    localparam int unsigned MEMSZ = 4096;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        done;
    logic        err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data_out = '0;

    mem_burst_initiator #(
        .START_ADDR(START),
        .DEPTH(DEPTH)
`ifdef BUSY_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_rw(req_rw),
        .req_size(req_size),
        .wdata(wdata),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_last(resp_last),
        .done(done),
        .err(err),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_access_size(mem_access_size),
        .mem_rw(mem_rw),
        .mem_enable(mem_enable),
        .mem_busy(mem_busy),
        .mem_data_out(mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    logic [7:0] gold [MEMSZ];
    logic [7:0] mem  [MEMSZ];
    bit         sync_mem = 1'b0;

    // Stimulus knobs, written only by the main sequence.
    bit          stall_en   = 1'b0;
    bit          stuck_busy = 1'b0;
    bit          cur_wr     = 1'b0;
    int          busy_at    = -1;
    int          busy_len   = 0;
    int          gap_at     = -1;
    int          gap_len    = 0;
    logic [31:0] wq [$];

    // Memory-side observations.
    int          cyc          = 0;
    int          en_cycles    = 0;
    int          stall_cycles = 0;
    int          beats_acc    = 0;
    bit          stall_hold   = 1'b0;
    logic [31:0] stall_addr   = '0;
    logic [31:0] stall_data   = '0;
    logic [31:0] addr_log [$];
    logic [1:0]  size_log [$];

    // Requester-side observations.
    logic [31:0] got_q [$];
    int          last_cnt  = 0;
    int          last_pos  = 0;
    int          wr_pulses = 0;
    int          widx      = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          err_cnt   = 0;
    int          err_cyc   = 0;

    function automatic bit in_array(input logic [31:0] a);
        return (a >= START) && ((a - START) <= MEMSZ - 4);
    endfunction

    function automatic int unsigned ofs(input logic [31:0] a);
        return a - START;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        if (!in_array(a)) return '0;
        return {gold[ofs(a)+3], gold[ofs(a)+2], gold[ofs(a)+1], gold[ofs(a)]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!in_array(a)) return '0;
        return {mem[ofs(a)+3], mem[ofs(a)+2], mem[ofs(a)+1], mem[ofs(a)]};
    endfunction

    task automatic gold_write(input logic [31:0] a, input logic [31:0] w);
        if (in_array(a)) begin
            gold[ofs(a)]   = w[7:0];
            gold[ofs(a)+1] = w[15:8];
            gold[ofs(a)+2] = w[23:16];
            gold[ofs(a)+3] = w[31:24];
        end
    endtask

    function automatic int size_beats(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    function automatic bit ref_reject(input logic [31:0] a, input int nb);
        longint last_byte;
        last_byte = longint'(a) + 4 * nb - 1;
        return (a % 4 != 0) || (a < START) || (last_byte > longint'(START) + longint'(DEPTH) - 1);
    endfunction

    // Byte-addressable memory: registered data_out, write on accepted beat.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (sync_mem) begin
            mem <= gold;
        end else if (!reset_n) begin
            stall_hold <= 1'b0;
        end else begin
            if (mem_enable) en_cycles <= en_cycles + 1;
            if (mem_enable && stall_hold) begin
                check("addr_stable", mem_address, stall_addr);
                if (!mem_rw) check("wdata_stable", mem_data_in, stall_data);
            end
            stall_hold <= mem_enable && mem_busy;
            stall_addr <= mem_address;
            stall_data <= mem_data_in;
            if (mem_enable && mem_busy) stall_cycles <= stall_cycles + 1;
            if (mem_enable && !mem_busy) begin
                beats_acc <= beats_acc + 1;
                addr_log.push_back(mem_address);
                size_log.push_back(mem_access_size);
                if (mem_rw) begin
                    mem_data_out <= mem_word(mem_address);
                end else if (in_array(mem_address)) begin
                    mem[ofs(mem_address)]   <= mem_data_in[7:0];
                    mem[ofs(mem_address)+1] <= mem_data_in[15:8];
                    mem[ofs(mem_address)+2] <= mem_data_in[23:16];
                    mem[ofs(mem_address)+3] <= mem_data_in[31:24];
                end
            end
        end
    end

    // Memory busy and write-data drivers, applied just after each rising edge.
    int busy_base = 0;
    int gap_used  = 0;
    int busy_run  = 0;
    always @(posedge clock) begin
        #1;
        if (beats_acc != busy_at) busy_base = stall_cycles;
        if (beats_acc != gap_at) gap_used = 0;
        mem_busy = stuck_busy || (beats_acc == busy_at && stall_cycles - busy_base < busy_len);
        if (!mem_busy && stall_en && busy_run < 2 && $urandom_range(0, 2) == 0) mem_busy = 1'b1;
        busy_run = mem_busy ? busy_run + 1 : 0;
        wdata_valid = 1'b1;
        if (beats_acc == gap_at && gap_used < gap_len) begin
            wdata_valid = 1'b0;
            gap_used++;
        end else if (stall_en && $urandom_range(0, 3) == 0) begin
            wdata_valid = 1'b0;
        end
        wdata = (widx < wq.size()) ? wq[widx] : '0;
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (resp_valid) begin
                got_q.push_back(resp_data);
                if (resp_last) begin
                    last_cnt <= last_cnt + 1;
                    last_pos <= got_q.size();
                end
            end
            if (wdata_ready) begin
                wr_pulses <= wr_pulses + 1;
                widx      <= widx + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if (cur_wr && !wdata_valid) check("gap_no_enable", 32'(mem_enable), 32'd0);
        end
    end

    task automatic wait_ready();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clock);
            #1;
            if (req_ready) break;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic send_req(input logic [31:0] addr, input logic rw, input logic [1:0] size, output int c0);
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_rw    = rw;
        req_size  = size;
        c0        = cyc;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [31:0] addr, input logic rw, input logic [1:0] size, input bit chk_lat);
        int nb, g0, l0, d0, e0, en0, wp0, b0, a0, w0, c0, k;
        bit rej;
        nb  = size_beats(size);
        rej = ref_reject(addr, nb);
        g0 = got_q.size(); l0 = last_cnt; d0 = done_cnt; e0 = err_cnt;
        en0 = en_cycles; wp0 = wr_pulses; b0 = beats_acc; a0 = addr_log.size();
        w0 = wq.size();
        if (!rw && !rej) for (int i = 0; i < nb; i++) wq.push_back($urandom);
        wait_ready();
        cur_wr = !rw;
        send_req(addr, rw, size, c0);
        for (k = 0; k < 2000; k++) begin
            @(negedge clock);
            #1;
            if (done_cnt != d0 || err_cnt != e0) break;
        end
        repeat (2) @(negedge clock);
        #1;
        cur_wr = 1'b0;
        check("end_events", 32'(done_cnt - d0 + err_cnt - e0), 32'd1);
        check("err_pulses", 32'(err_cnt - e0), rej ? 32'd1 : 32'd0);
        check("done_pulses", 32'(done_cnt - d0), rej ? 32'd0 : 32'd1);
        if (rej) begin
            check("reject_no_enable", 32'(en_cycles - en0), 32'd0);
            check("reject_ready", 32'(req_ready), 32'd1);
        end else begin
            check("beats", 32'(beats_acc - b0), 32'(nb));
            for (int i = 0; i < nb; i++) begin
                if (a0 + i < addr_log.size()) begin
                    check("beat_addr", addr_log[a0+i], addr + 32'(4 * i));
                    check("beat_size", 32'(size_log[a0+i]), 32'(size));
                end
            end
            if (rw) begin
                check("resp_count", 32'(got_q.size() - g0), 32'(nb));
                for (int i = 0; i < nb; i++)
                    if (g0 + i < got_q.size()) check("rdata", got_q[g0+i], gold_word(addr + 32'(4 * i)));
                check("resp_last_cnt", 32'(last_cnt - l0), 32'd1);
                check("resp_last_pos", 32'(last_pos), 32'(g0 + nb));
            end else begin
                check("wdata_ready_cnt", 32'(wr_pulses - wp0), 32'(nb));
                for (int i = 0; i < nb; i++) gold_write(addr + 32'(4 * i), wq[w0+i]);
            end
            if (chk_lat) check("latency", 32'(done_cyc - c0), rw ? 32'(2 * nb + 1) : 32'(nb + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, e0, g0, c0, sc0, k;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_rw      = 1'b0;
        req_size    = '0;
        wdata       = '0;
        wdata_valid = 1'b0;
        mem_busy    = 1'b0;
        for (int i = 0; i < MEMSZ; i++) gold[i] = 8'($urandom);
        gold[0] = 8'h11; gold[1] = 8'h22; gold[2] = 8'h33; gold[3] = 8'h44;
        sync_mem = 1'b1;
        repeat (3) @(posedge clock);
        #1 sync_mem = 1'b0;
        @(negedge clock);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_outputs", {mem_address ^ resp_data}, 32'd0);
        check("rst_pulses", 32'({done, err, resp_valid, resp_last, wdata_ready}), 32'd0);
        #1 reset_n = 1'b1;

        // Single-word read of the known bytes.
        run_req(START, 1'b1, 2'b00, 1'b1);
        check("single_word", got_q[got_q.size()-1], 32'h4433_2211);

        // Four-word read with a three-cycle busy stall on the second beat.
        sc0      = stall_cycles;
        busy_at  = beats_acc + 1;
        busy_len = 3;
        run_req(START + 32'h10, 1'b1, 2'b01, 1'b0);
        busy_at = -1;
        check("stall_cycles", 32'(stall_cycles - sc0), 32'd3);

        // Sixteen-word write with a two-cycle wdata gap, then read back.
        gap_at  = beats_acc + 8;
        gap_len = 2;
        run_req(START + 32'h100, 1'b0, 2'b11, 1'b0);
        gap_at = -1;
        run_req(START + 32'h100, 1'b1, 2'b11, 1'b1);

        // Window and alignment boundaries.
        run_req(START + 32'h2, 1'b1, 2'b00, 1'b0);
        run_req(32'h8011_FFF0, 1'b1, 2'b11, 1'b0);
        run_req(32'h8001_FFFC, 1'b0, 2'b00, 1'b0);
        run_req(32'hFFFF_FFF0, 1'b1, 2'b11, 1'b0);
        run_req(START + DEPTH - 32'd60, 1'b1, 2'b11, 1'b0);
        run_req(START + DEPTH - 32'd64, 1'b1, 2'b11, 1'b1);

        // Reset in the middle of an eight-word read after three beats.
        b0 = beats_acc; d0 = done_cnt; e0 = err_cnt;
        wait_ready();
        send_req(START + 32'h200, 1'b1, 2'b10, c0);
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            #1;
            if (beats_acc - b0 >= 3) break;
        end
        check("rst_mid_reach", 32'(beats_acc - b0), 32'd3);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_enable", 32'(mem_enable), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_addr", mem_address, 32'd0);
        check("rst_mid_pulses", 32'({done, err, resp_valid, resp_last}), 32'd0);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        repeat (6) @(negedge clock);
        #1;
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_mid_no_err", 32'(err_cnt - e0), 32'd0);
        run_req(START + 32'h20, 1'b1, 2'b00, 1'b1);

        // Randomized requests, mostly legal, with random stalls.
        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            int          kind;
            kind     = $urandom_range(0, 7);
            stall_en = ($urandom_range(0, 1) == 1);
            case (kind)
                0:       a = START + 32'($urandom_range(0, 1000) * 4) + 32'($urandom_range(1, 3));
                1:       a = START - 32'($urandom_range(1, 64) * 4);
                default: a = START + 32'($urandom_range(0, 1000) * 4);
            endcase
            run_req(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), !stall_en);
        end
        stall_en = 1'b0;

`ifdef BUSY_TIMEOUT_EN
        d0 = done_cnt; e0 = err_cnt; g0 = got_q.size();
        stuck_busy = 1'b1;
        wait_ready();
        send_req(START + 32'h40, 1'b1, 2'b00, c0);
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            #1;
            if (err_cnt != e0) break;
        end
        check("timeout_err", 32'(err_cnt - e0), 32'd1);
        check("timeout_when", 32'(err_cyc - c0), 32'd5);
        stuck_busy = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("timeout_no_resp", 32'(got_q.size() - g0), 32'd0);
        check("timeout_ready", 32'(req_ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
